// File: rtl/uds_tile_loader.sv
// Streams up to A 32-bit words into a tile, issues it to the engine, then waits for completion or a timeout.
// idata_valid rises 1 cycle after the last accepted word; in_ready is held low from tile end until the engine finishes.
module uds_tile_loader #(
    parameter int A       = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    input  logic [1:0]      cfg_function_mode,
    input  logic [1:0]      cfg_scale_factor,
    output logic [A*32-1:0] idata,
    output logic            idata_valid,
    output logic            active,
    output logic [1:0]      function_mode,
    output logic [1:0]      scale_factor,
    input  logic            odata_valid,
    output logic            tile_done,
    output logic [15:0]     tile_count,
    output logic            err_len,
    output logic            err_timeout
);

    localparam int AW = (A > 1) ? $clog2(A) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(A - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] ACT   = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] widx;
    logic [WW-1:0] wcnt;
    logic          accept;
    logic          tile_end;

    assign accept   = in_valid && in_ready;
    assign tile_end = in_last || (widx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FILL;
            widx          <= '0;
            wcnt          <= '0;
            in_ready      <= 1'b0;
            idata         <= '0;
            idata_valid   <= 1'b0;
            active        <= 1'b0;
            function_mode <= 2'b00;
            scale_factor  <= 2'b00;
            tile_done     <= 1'b0;
            tile_count    <= 16'd0;
            err_len       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            idata_valid <= 1'b0;
            active      <= 1'b0;
            tile_done   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        idata[32*int'(widx) +: 32] <= in_data;
                        if (widx == '0) begin
                            function_mode <= cfg_function_mode;
                            scale_factor  <= cfg_scale_factor;
                        end
                        if (tile_end) begin
                            // Unfilled words are already zero: idata is cleared on every exit from WAIT.
                            state       <= ISSUE;
                            in_ready    <= 1'b0;
                            idata_valid <= 1'b1;
                            err_len     <= in_last != (widx == LAST_IDX);
                            widx        <= '0;
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state  <= ACT;
                    active <= 1'b1;
                end
                ACT: begin
                    state <= WAIT;
                    wcnt  <= '0;
                end
                WAIT: begin
                    // Completion takes priority over a timeout landing on the same cycle.
                    if (odata_valid) begin
                        tile_done  <= 1'b1;
                        tile_count <= tile_count + 16'd1;
                        idata      <= '0;
                        widx       <= '0;
                        in_ready   <= 1'b1;
                        state      <= FILL;
                    end else if (wcnt == WAIT_MAX) begin
                        err_timeout <= 1'b1;
                        idata       <= '0;
                        widx        <= '0;
                        in_ready    <= 1'b1;
                        state       <= FILL;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
